// File: rtl/clock_phase_monitor.sv
// clock_phase_monitor
// Samples the four quadrature phase outputs of the clock phasing generator.
// Decodes the current quarter-phase and checks for forward rotation and a
// constant quarter length. Declares lock after LOCK_PERIODS clean periods.
// While locked, any fault raises a one-cycle err pulse, bumps a saturating
// error counter and drops back to IDLE.
module clock_phase_monitor #(
    parameter int CNT_W        = 8,
    parameter int LOCK_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_0,
    input  logic             clk_90,
    input  logic             clk_180,
    input  logic             clk_270,
    output logic             locked,
    output logic [1:0]       phase_idx,
    output logic [CNT_W-1:0] quarter_len,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] DWELL_MAX    = '1;
    localparam int               MATCH_TARGET = 4 * LOCK_PERIODS;
    localparam int               MATCH_W      = $clog2(MATCH_TARGET + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Only the four legal quadrature patterns are valid.
    function automatic logic pat_valid(input logic [3:0] p);
        case (p)
            4'b1001, 4'b0011, 4'b0110, 4'b1100: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Quarter index of a legal pattern; 0 for illegal ones (callers gate on pat_valid).
    function automatic logic [1:0] pat_idx(input logic [3:0] p);
        case (p)
            4'b1001: return 2'd0;
            4'b0011: return 2'd1;
            4'b0110: return 2'd2;
            4'b1100: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    logic [3:0]         r_ph_q;
    logic [3:0]         r_ph_d;
    logic [CNT_W-1:0]   r_dwell;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_ref_len;
    logic               r_ref_set;
    logic [MATCH_W-1:0] r_match;
    logic [CNT_W-1:0]   r_quarter_len;
    logic [1:0]         r_phase_idx;
    logic               r_err;
    logic [7:0]         r_err_count;

    logic               w_change;
    logic               w_q_valid;
    logic               w_d_valid;
    logic [1:0]         w_idx_q;
    logic [1:0]         w_idx_d_next;
    logic               w_step_valid;
    logic               w_len_bad;
    logic               w_fault;

    logic               w_acq_start;
    logic               w_ref_capture;
    logic               w_match_inc;
    logic               w_lock_enter;
    logic               w_err_pulse;

    // Step and fault qualification; the dwell value seen at a change is the
    // length of the quarter that just completed.
    assign w_change     = (r_ph_q != r_ph_d);
    assign w_q_valid    = pat_valid(r_ph_q);
    assign w_d_valid    = pat_valid(r_ph_d);
    assign w_idx_q      = pat_idx(r_ph_q);
    assign w_idx_d_next = pat_idx(r_ph_d) + 2'd1;
    assign w_step_valid = w_change && w_q_valid && w_d_valid && (w_idx_q == w_idx_d_next);
    assign w_len_bad    = (r_state != ST_IDLE) && r_ref_set && w_change && (r_dwell != r_ref_len);
    assign w_fault      = !w_q_valid || (w_change && !w_step_valid) ||
                          (r_dwell == DWELL_MAX) || w_len_bad;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; faults take priority over completing lock.
    always_comb begin
        w_state_nxt   = r_state;
        w_acq_start   = 1'b0;
        w_ref_capture = 1'b0;
        w_match_inc   = 1'b0;
        w_lock_enter  = 1'b0;
        w_err_pulse   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_step_valid) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_acq_start = 1'b1;
                end
            end
            ST_ACQUIRE: begin
                if (w_fault) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_step_valid) begin
                    if (!r_ref_set) begin
                        w_ref_capture = 1'b1;
                    end else begin
                        w_match_inc = 1'b1;
                        if (r_match == MATCH_W'(MATCH_TARGET - 1)) begin
                            w_state_nxt  = ST_LOCKED;
                            w_lock_enter = 1'b1;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (w_fault) begin
                    w_state_nxt = ST_IDLE;
                    w_err_pulse = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Input sampling, dwell measurement and phase reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph_q      <= 4'b0000;
            r_ph_d      <= 4'b0000;
            r_dwell     <= '0;
            r_phase_idx <= 2'd0;
        end else begin
            r_ph_q <= {clk_270, clk_180, clk_90, clk_0};
            r_ph_d <= r_ph_q;
            if (w_change)
                r_dwell <= CNT_W'(1);
            else if (r_dwell != DWELL_MAX)
                r_dwell <= r_dwell + CNT_W'(1);
            if (w_q_valid)
                r_phase_idx <= w_idx_q;
        end
    end

    // Reference length, match counting and reported quarter length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_len     <= '0;
            r_ref_set     <= 1'b0;
            r_match       <= '0;
            r_quarter_len <= '0;
        end else begin
            if (w_acq_start) begin
                r_ref_set <= 1'b0;
                r_match   <= '0;
            end
            if (w_ref_capture) begin
                r_ref_len <= r_dwell;
                r_ref_set <= 1'b1;
                r_match   <= MATCH_W'(1);
            end
            if (w_match_inc)
                r_match <= r_match + MATCH_W'(1);
            if (w_state_nxt == ST_IDLE) begin
                r_ref_set <= 1'b0;
                r_match   <= '0;
            end
            if (w_lock_enter)
                r_quarter_len <= r_ref_len;
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_err <= w_err_pulse;
            if (w_err_pulse && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign locked      = (r_state == ST_LOCKED);
    assign phase_idx   = r_phase_idx;
    assign quarter_len = r_quarter_len;
    assign err         = r_err;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_clock_phase_monitor.sv
// Directed bench for clock_phase_monitor with default parameters.
module tb_clock_phase_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_0 = 1'b0;
    logic       clk_90 = 1'b0;
    logic       clk_180 = 1'b0;
    logic       clk_270 = 1'b0;
    logic       locked;
    logic [1:0] phase_idx;
    logic [7:0] quarter_len;
    logic       err;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;
    int g_pos = 0;
    int g_err_seen = 0;

    logic [3:0] PAT [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};

    clock_phase_monitor #(.CNT_W(8), .LOCK_PERIODS(2)) dut (
        .clk(clk), .rst(rst),
        .clk_0(clk_0), .clk_90(clk_90), .clk_180(clk_180), .clk_270(clk_270),
        .locked(locked), .phase_idx(phase_idx), .quarter_len(quarter_len),
        .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic [3:0] p);
        {clk_270, clk_180, clk_90, clk_0} = p;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_pins(4'b0000);
        tick();
        tick();
        rst = 1'b0;
        g_pos = 0;
    endtask

    // Drives the next forward pattern for qlen cycles, tallying err pulses.
    task automatic drive_quarter(input int qlen);
        for (int c = 0; c < qlen; c++) begin
            set_pins(PAT[2'(g_pos % 4)]);
            tick();
            if (err === 1'b1) g_err_seen++;
        end
        g_pos++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_pins(4'b0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({locked, err, err_count, quarter_len, phase_idx} !== 19'd0) begin
                n_errors++;
                $display("FAIL reset_init cyc=%0d got locked=%b err=%b cnt=%0d qlen=%0d idx=%0d required all zero",
                         i, locked, err, err_count, quarter_len, phase_idx);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_q1();
        apply_reset();
        for (int j = 0; j <= 18; j++) begin
            set_pins(PAT[2'(j % 4)]);
            tick();
            n_checks++;
            if (err !== 1'b0) begin
                n_errors++;
                $display("FAIL q1_err j=%0d got=%b required=0", j, err);
            end
            n_checks++;
            if (locked !== (j >= 10)) begin
                n_errors++;
                $display("FAIL q1_locked j=%0d got=%b required=%b", j, locked, (j >= 10));
            end
            if (j >= 1) begin
                n_checks++;
                if (phase_idx !== 2'((j - 1) % 4)) begin
                    n_errors++;
                    $display("FAIL q1_phase j=%0d got=%0d required=%0d", j, phase_idx, (j - 1) % 4);
                end
            end
            if (j >= 10) begin
                n_checks++;
                if (quarter_len !== 8'd1) begin
                    n_errors++;
                    $display("FAIL q1_qlen j=%0d got=%0d required=1", j, quarter_len);
                end
            end
        end
    endtask

    task automatic test_clean_q3();
        int n;
        apply_reset();
        for (int j = 0; j < 12; j++) begin
            for (int c = 0; c < 3; c++) begin
                set_pins(PAT[2'(j % 4)]);
                tick();
                n = 3 * j + c + 1;
                n_checks++;
                if (err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL q3_err edge=%0d got=%b required=0", n, err);
                end
                n_checks++;
                if (locked !== (n >= 29)) begin
                    n_errors++;
                    $display("FAIL q3_locked edge=%0d got=%b required=%b", n, locked, (n >= 29));
                end
                if (n >= 2) begin
                    n_checks++;
                    if (phase_idx !== 2'(((n - 2) / 3) % 4)) begin
                        n_errors++;
                        $display("FAIL q3_phase edge=%0d got=%0d required=%0d", n, phase_idx, ((n - 2) / 3) % 4);
                    end
                end
                if (n >= 29) begin
                    n_checks++;
                    if (quarter_len !== 8'd3) begin
                        n_errors++;
                        $display("FAIL q3_qlen edge=%0d got=%0d required=3", n, quarter_len);
                    end
                end
            end
        end
    endtask

    task automatic test_reverse();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            set_pins(PAT[2'((4 - (i % 4)) % 4)]);
            tick();
            n_checks++;
            if (locked !== 1'b0 || err !== 1'b0) begin
                n_errors++;
                $display("FAIL rev_state i=%0d got locked=%b err=%b required 0 0", i, locked, err);
            end
        end
        n_checks++;
        if (err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL rev_count got=%0d required=0", err_count);
        end
    endtask

    task automatic test_stretch();
        int exp_cnt;
        apply_reset();
        g_err_seen = 0;
        repeat (10) drive_quarter(3);
        n_checks++;
        if (locked !== 1'b1 || quarter_len !== 8'd3 || g_err_seen != 0) begin
            n_errors++;
            $display("FAIL st_lock got locked=%b qlen=%0d errs=%0d required 1 3 0", locked, quarter_len, g_err_seen);
        end
        drive_quarter(4);
        n_checks++;
        if (locked !== 1'b1 || err !== 1'b0 || g_err_seen != 0) begin
            n_errors++;
            $display("FAIL st_long got locked=%b err=%b errs=%0d required 1 0 0", locked, err, g_err_seen);
        end
        set_pins(PAT[2'(g_pos % 4)]);
        tick();
        n_checks++;
        if (err !== 1'b0 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL st_pre got err=%b locked=%b required 0 1", err, locked);
        end
        tick();
        n_checks++;
        if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
            n_errors++;
            $display("FAIL st_pulse got err=%b locked=%b cnt=%0d required 1 0 1", err, locked, err_count);
        end
        tick();
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL st_post got err=%b required 0", err);
        end
        g_pos++;
        repeat (8) drive_quarter(3);
        n_checks++;
        if (locked !== 1'b0) begin
            n_errors++;
            $display("FAIL st_early got locked=%b required 0", locked);
        end
        drive_quarter(3);
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++;
            $display("FAIL st_relock got locked=%b required 1", locked);
        end
        for (int it = 2; it <= 300; it++) begin
            g_err_seen = 0;
            drive_quarter(4);
            repeat (10) drive_quarter(3);
            exp_cnt = (it < 255) ? it : 255;
            n_checks++;
            if (g_err_seen != 1 || locked !== 1'b1 || int'(err_count) != exp_cnt) begin
                n_errors++;
                $display("FAIL st_iter it=%0d got pulses=%0d locked=%b cnt=%0d required 1 1 %0d",
                         it, g_err_seen, locked, err_count, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_midlock();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({locked, err, err_count, quarter_len, phase_idx} !== 19'd0) begin
                n_errors++;
                $display("FAIL rst_mid cyc=%0d got locked=%b err=%b cnt=%0d qlen=%0d idx=%0d required all zero",
                         i, locked, err, err_count, quarter_len, phase_idx);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (locked !== 1'b0 || phase_idx !== 2'd0 || err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL rst_after got locked=%b idx=%0d cnt=%0d required 0 0 0", locked, phase_idx, err_count);
        end
    endtask

    task automatic test_freeze();
        apply_reset();
        repeat (10) drive_quarter(3);
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++;
            $display("FAIL fz_lock got locked=%b required 1", locked);
        end
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k < 254) begin
                if (err !== 1'b0 || locked !== 1'b1) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL fz_hold k=%0d got err=%b locked=%b required 0 1", k, err, locked);
                end
            end else if (k == 254) begin
                n_checks++;
                if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
                    n_errors++;
                    $display("FAIL fz_sat got err=%b locked=%b cnt=%0d required 1 0 1", err, locked, err_count);
                end
            end else begin
                n_checks++;
                if (err !== 1'b0 || locked !== 1'b0) begin
                    n_errors++;
                    $display("FAIL fz_after k=%0d got err=%b locked=%b required 0 0", k, err, locked);
                end
            end
        end
        n_checks++;
        if (err_count !== 8'd1) begin
            n_errors++;
            $display("FAIL fz_count got=%0d required=1", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean_q1();
        test_clean_q3();
        test_reverse();
        test_stretch();
        test_reset_midlock();
        test_freeze();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_phase_monitor.md
# clock_phase_monitor

Receive-side checker for the four quadrature phase outputs (clk_0, clk_90, clk_180, clk_270) of the clock phasing generator. All inputs are produced in the same clk domain. The block samples them, decodes the current quarter-phase, verifies correct rotation and constant quarter length, and declares lock after a programmable number of clean periods. It sits beside the generator as a built-in self-check and phase reporter for downstream logic.

## Interface
- CNT_W, 8: width of the dwell counter and of quarter_len; maximum measurable quarter = 2^CNT_W-2 cycles.
- LOCK_PERIODS, 2: number of full clean periods (4 quarters each) required for lock; must be ≥1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- clk_0  input  1  phase 0 signal.
- clk_90  input  1  phase 90 signal.
- clk_180  input  1  phase 180 signal.
- clk_270  input  1  phase 270 signal.
- locked  output  1  high while FSM is in LOCKED.
- phase_idx  output  2  decoded quarter index of sampled pattern.
- quarter_len  output  CNT_W  measured quarter length in clk cycles, captured at lock entry.
- err  output  1  one-cycle pulse on any fault while LOCKED.
- err_count  output  8  count of err pulses, saturates at 255.

## Operation
- Sampling: ph_q <= {clk_270,clk_180,clk_90,clk_0} each cycle; ph_d <= ph_q.
- Decode of ph_q: 1001→0, 0011→1, 0110→2, 1100→3; any other value is invalid.
- change = (ph_q != ph_d). Dwell counter: on change load 1, else increment, saturating at 2^CNT_W-1.
- At a change, completed quarter length = dwell value before the load.
- Valid step: change with both ph_d and ph_q valid and idx(ph_q) = idx(ph_d)+1 mod 4.
- Fault: invalid ph_q; change that is not a valid step; dwell reaching saturation; in ACQUIRE/LOCKED with reference set, completed quarter length ≠ ref_len.
- FSM states IDLE, ACQUIRE, LOCKED:
  - IDLE: faults ignored. First valid step → ACQUIRE with ref unset, match count 0 (its partial dwell is discarded).
  - ACQUIRE: next valid step captures ref_len = completed length, match count = 1. Each further valid step with length = ref_len increments match count. When match count reaches 4*LOCK_PERIODS → LOCKED, quarter_len <= ref_len. Any fault → IDLE, no err.
  - LOCKED: valid matching steps keep state. Any fault → err pulse, err_count+1 (saturating), state → IDLE.
- phase_idx updates to idx(ph_q) whenever ph_q is valid; holds last value otherwise.
- quarter_len holds until next lock entry or reset. err_count cleared only by reset.
- Simultaneous events: a cycle that is both a fault and would complete lock counts as a fault (fault priority).

## Timing
- Reset (synchronous, any state, including mid-lock): ph_q=ph_d=0000, dwell=0, state IDLE, locked=0, phase_idx=0, quarter_len=0, err=0, err_count=0, ref unset. First pattern after reset is a change from invalid, so it is never a valid step.
- Input pin change → ph_q: 1 cycle. ph_q change → err/locked/FSM update: next edge. Pin-to-err latency: 2 cycles.
- locked rises the edge after the step that completes 4*LOCK_PERIODS matches; falls together with the err pulse.
- Lock acquisition from a clean stream: 1 + 4*LOCK_PERIODS valid steps after the first valid pattern is sampled (9 for default).
- Quarter length 1 (pattern changes every cycle) is supported; dwell stays 1.

## Test plan
- Reset: hold rst 2 cycles mid-stream → locked=0, err=0, err_count=0, quarter_len=0, phase_idx=0 next cycle.
- Clean stream, quarter=1, defaults → locked high after 9th valid step; quarter_len=1; phase_idx cycles 0,1,2,3; err never asserted.
- Clean stream, quarter=3 → locked after 9 steps, quarter_len=3; phase_idx holds each value 3 cycles.
- Reverse rotation (1001→1100→0110…) for 100 cycles → locked stays 0, err stays 0, err_count 0.
- Locked at quarter=3, stretch one quarter to 4 cycles → single 1-cycle err pulse, err_count=1, locked drops same edge, relocks 9 steps later; repeat 300 times → err_count saturates at 255.
- Locked, freeze inputs at 0011 → err when dwell hits 255 (CNT_W=8), locked=0; rst mid-lock → immediate return to reset values.
